spi_master_ctrl: RTL and testbench

//  Host-side SPI master that drives our 32x8 SPI slave register file. Accepts one read/write request
//  per valid/ready handshake, serialises command/address/data on cs/mosi, captures read data from miso,

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_shifter.sv | 47 ++++
 rtl/spi_master_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states and command opcodes.
package spi_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        WAIT_RDY,
        RDATA,
        WAIT_DONE,
        RESP,
        ERR
    } spi_state_e;

    localparam logic SPI_OP_WR = 1'b1;
    localparam logic SPI_OP_RD = 1'b0;

endpackage

// File: rtl/spi_shifter.sv
// LSB-first byte shifter with bit counter: parallel load and shift-out on sout,
// serial capture from sin entering at the MSB.
module spi_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    input  logic             cnt_clr,
    input  logic             cnt_inc,
    output logic             sout,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] sh_q;
    logic [CNT_W-1:0] cnt_q;

    // Shift register; load takes priority over shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= load_data;
        end else if (shift) begin
            sh_q <= {sin, sh_q[WIDTH-1:1]};
        end
    end

    // Bit counter, restarted by a load or an explicit clear.
    always_ff @(posedge clk) begin
        if (rst || load || cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sout = sh_q[0];
    assign data = sh_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: one request per handshake, serialises cmd/addr/data,
// captures read data, waits for slave completion and pulses a response.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              cs,
    output logic              mosi,
    input  logic              miso,
    input  logic              slv_ready,
    input  logic              slv_done
);

    localparam int unsigned SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    spi_state_e        state_q, state_d;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              tmo_clr, tmo_hit, accept;

    logic              sh_load, sh_shift, cnt_clr, cnt_inc, sh_sout;
    logic [SH_W-1:0]   sh_load_data, sh_data;
    logic [CNT_W-1:0]  cnt;

    logic              mosi_d, cs_d, req_ready_d, rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    // The address is held only in the shifter; write data waits in wdata_q until ADDR ends.
    spi_shifter #(
        .WIDTH (SH_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift     (sh_shift),
        .sin       (miso),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .sout      (sh_sout),
        .data      (sh_data),
        .cnt       (cnt)
    );

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

    // Next state, shifter control and next value of every registered output.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        sh_load      = 1'b0;
        sh_load_data = '0;
        sh_shift     = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        tmo_clr      = 1'b0;
        mosi_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept       = 1'b1;
                    state_d      = CMD;
                    sh_load      = 1'b1;
                    sh_load_data = SH_W'(req_addr);
                    mosi_d       = req_wr;
                end
            end
            CMD: begin
                // mosi is registered, so each cycle presents the bit for the next one.
                state_d  = ADDR;
                mosi_d   = sh_sout;
                sh_shift = 1'b1;
                cnt_clr  = 1'b1;
            end
            ADDR: begin
                if (cnt == CNT_W'(ADDR_W - 1)) begin
                    cnt_clr = 1'b1;
                    if (wr_q == SPI_OP_WR) begin
                        // Bit 0 goes straight out; the shifter holds the rest.
                        state_d      = WDATA;
                        sh_load      = 1'b1;
                        sh_load_data = SH_W'(wdata_q >> 1);
                        mosi_d       = wdata_q[0];
                    end else begin
                        state_d = WAIT_RDY;
                        tmo_clr = 1'b1;
                    end
                end else begin
                    mosi_d   = sh_sout;
                    sh_shift = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            WDATA: begin
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    state_d = WAIT_DONE;
                    tmo_clr = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    mosi_d   = sh_sout;
                    sh_shift = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (slv_ready) begin
                    state_d = RDATA;
                    cnt_clr = 1'b1;
                end else if (slv_done || tmo_hit) begin
                    state_d = ERR;
                end
            end
            RDATA: begin
                sh_shift = 1'b1;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    state_d = WAIT_DONE;
                    tmo_clr = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (slv_done) begin
                    state_d = RESP;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            RESP, ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cs_d        = state_d inside {CMD, ADDR, WDATA, WAIT_RDY, RDATA, WAIT_DONE};
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP) || (state_d == ERR);
        rsp_err_d   = (state_d == ERR);
        rsp_rdata_d = '0;
        if (state_d == RESP && wr_q == SPI_OP_RD) begin
            // Captured bits enter at the MSB, so the byte sits at the top of the shifter.
            rsp_rdata_d = sh_data[SH_W-1 -: DATA_W];
        end
    end

    // State, request latches, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            tmo_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            cs        <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            cs        <= cs_d;
            mosi      <= mosi_d;
            if (accept) begin
                wr_q    <= req_wr;
                wdata_q <= req_wdata;
            end
            if (tmo_clr) begin
                tmo_q <= '0;
            end else if ((state_q == WAIT_RDY || state_q == WAIT_DONE) &&
                         tmo_q != TMO_W'(TIMEOUT)) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: the bench plays the SPI slave (32x8 register file)
// and predicts every response from request parameters and slave delays.
module tb_spi_master_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 64;

    logic          clk, rst;
    logic          req_valid, req_ready, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          cs, mosi, miso, slv_ready, slv_done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int last_waits;

    logic [7:0] slv_mem [32];
    logic [7:0] ref_mem [32];

    spi_master_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .slv_ready (slv_ready),
        .slv_done  (slv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction; called and returning at a negedge. Delays < 0 mean "never".
    // abort_idx > 0 asserts rst in that cycle of the frame instead of completing.
    task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input int rdy_dly, input int done_dly, input int abort_idx,
                           input bit nxt_valid, input bit nxt_wr, input logic [7:0] nxt_addr,
                           input string tag);
        int flen, wait0, rdy_idx, done_idx, exp_idx, rsp_idx, waits, bad;
        int cs_bad, mosi_bad, rdy_bad;
        bit exp_err, got_err, got_cs;
        logic [7:0]  rbyte, exp_rdata, got_rdata;
        logic [31:0] frame, exp_frame;

        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        waits = 0;
        while (req_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        last_waits = waits;
        if (req_ready !== 1'b1) begin
            check({tag, "_accept"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end

        // Timing model: cycle 1 = command bit, then address, then data (writes).
        flen      = 1 + AW + (wr ? DW : 0);
        wait0     = flen + 1;
        rbyte     = slv_mem[addr[4:0]];
        exp_frame = 32'(wr) | (32'(addr) << 1) | (wr ? (32'(wdata) << (1 + AW)) : 32'd0);
        rdy_idx   = -1;
        done_idx  = -1;
        exp_rdata = 8'h00;
        exp_err   = 1'b1;
        if (wr) begin
            if (done_dly >= 0) done_idx = wait0 + done_dly;
            if (done_dly >= 0 && done_dly < TMO) begin
                exp_idx = done_idx + 1;
                exp_err = 1'b0;
            end else begin
                exp_idx = wait0 + TMO;
            end
        end else if (rdy_dly < 0) begin
            // Slave never signals ready; a done pulse here is a slave-side abort.
            if (done_dly >= 0 && done_dly < TMO) begin
                done_idx = wait0 + done_dly;
                exp_idx  = done_idx + 1;
            end else begin
                exp_idx = wait0 + TMO;
            end
        end else begin
            rdy_idx = wait0 + rdy_dly;
            if (done_dly >= 0) done_idx = rdy_idx + DW + 1 + done_dly;
            if (done_dly >= 0 && done_dly < TMO) begin
                exp_idx   = done_idx + 1;
                exp_err   = 1'b0;
                exp_rdata = ref_mem[addr[4:0]];
            end else begin
                exp_idx = rdy_idx + DW + 1 + TMO;
            end
        end

        @(posedge clk);
        frame = '0;
        cs_bad = 0; mosi_bad = 0; rdy_bad = 0;
        rsp_idx = -1;
        got_err = 1'b0; got_cs = 1'b0; got_rdata = '0;
        for (int idx = 1; idx <= exp_idx + 4; idx++) begin
            @(negedge clk);
            if (idx == 1) begin
                req_valid = nxt_valid;
                req_wr    = nxt_wr;
                req_addr  = nxt_addr;
                req_wdata = 8'h00;
            end
            if (rsp_valid === 1'b1) begin
                rsp_idx   = idx;
                got_err   = rsp_err;
                got_rdata = rsp_rdata;
                got_cs    = cs;
                break;
            end
            if (idx == abort_idx) begin
                rst = 1'b1;
                slv_ready = 1'b0; slv_done = 1'b0; miso = 1'b0;
                @(negedge clk);
                check({tag, "_rst_outs"}, 32'({cs, mosi, req_ready, rsp_valid}), 32'd0);
                rst = 1'b0;
                bad = 0;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    if (rsp_valid !== 1'b0) bad++;
                end
                check({tag, "_no_rsp"}, 32'(bad), 32'd0);
                check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
                return;
            end
            if (cs !== 1'b1) cs_bad++;
            if (req_ready !== 1'b0) rdy_bad++;
            if (idx <= flen) frame[idx-1] = mosi;
            else if (mosi !== 1'b0) mosi_bad++;
            slv_ready = (idx == rdy_idx);
            slv_done  = (idx == done_idx);
            miso      = (rdy_idx > 0 && idx > rdy_idx && idx <= rdy_idx + DW) ?
                        rbyte[idx-rdy_idx-1] : 1'b0;
        end
        slv_ready = 1'b0; slv_done = 1'b0; miso = 1'b0;

        check({tag, "_latency"}, 32'(rsp_idx), 32'(exp_idx));
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_rdata"}, 32'(got_rdata), 32'(exp_rdata));
        check({tag, "_cs_at_rsp"}, 32'(got_cs), 32'd0);
        check({tag, "_frame"}, frame, exp_frame);
        check({tag, "_frame_cs"}, 32'(cs_bad), 32'd0);
        check({tag, "_mosi_quiet"}, 32'(mosi_bad), 32'd0);
        check({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);

        if (wr && !exp_err && rsp_idx == exp_idx) begin
            slv_mem[frame[4+1:1]] = frame[AW+DW:AW+1];
            ref_mem[addr[4:0]]    = wdata;
        end

        @(negedge clk);
        check({tag, "_after"}, 32'({rsp_valid, req_ready, cs}), 32'b010);
    endtask

    initial begin
        bit          r_wr;
        logic [7:0]  r_addr, r_data;
        int          r_rdy, r_done;

        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        miso = 1'b0; slv_ready = 1'b0; slv_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
            slv_mem[i] = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({req_ready, rsp_valid, rsp_err, cs, mosi}), 32'd0);
        check("reset_rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd1);

        // Directed cases.
        run_txn(1'b1, 8'h05, 8'hA5, 0, 2, -1, 1'b0, 1'b0, 8'h00, "t1_wr");
        run_txn(1'b0, 8'h05, 8'h00, 1, 1, -1, 1'b0, 1'b0, 8'h00, "t2_rd");
        run_txn(1'b0, 8'h07, 8'h00, -1, -1, -1, 1'b0, 1'b0, 8'h00, "t3_rdy_tmo");
        run_txn(1'b1, 8'h0A, 8'h3C, 0, 0, 1 + AW + 1 + 3, 1'b0, 1'b0, 8'h00, "t4_rst");
        run_txn(1'b1, 8'h0A, 8'h5A, 0, 1, -1, 1'b0, 1'b0, 8'h00, "t4_wr");
        run_txn(1'b0, 8'h0A, 8'h00, 0, 0, -1, 1'b0, 1'b0, 8'h00, "t4_rd");
        run_txn(1'b1, 8'h1F, 8'hC3, 0, 0, -1, 1'b1, 1'b0, 8'h1F, "t5_wr");
        run_txn(1'b0, 8'h1F, 8'h00, 2, 0, -1, 1'b0, 1'b0, 8'h00, "t5_rd");
        check("t5_b2b_accept", 32'(last_waits), 32'd0);
        run_txn(1'b1, 8'h03, 8'h96, 0, TMO - 1, -1, 1'b0, 1'b0, 8'h00, "t6_done_vs_tmo");
        run_txn(1'b1, 8'h04, 8'h69, 0, TMO, -1, 1'b0, 1'b0, 8'h00, "t6_done_tmo");
        run_txn(1'b0, 8'h03, 8'h00, TMO - 1, 0, -1, 1'b0, 1'b0, 8'h00, "rdy_last_cycle");
        run_txn(1'b0, 8'h09, 8'h00, -1, 3, -1, 1'b0, 1'b0, 8'h00, "rd_slave_abort");

        // Randomised traffic.
        for (int i = 0; i < 24; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = 8'($urandom_range(0, 255));
            r_data = 8'($urandom_range(0, 255));
            r_rdy  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            r_done = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            run_txn(r_wr, r_addr, r_data, r_rdy, r_done, -1, 1'b0, 1'b0, 8'h00,
                    $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
